mem_request_arbiter: RTL and testbench

// - Sits directly upstream of memory_driver and merges two BST engine request streams onto its single mem_* port.
// - Requester 0 is the insert/delete engine (ins_*); requester 1 is the search engine (srch_*).
// - Arbitrates round-robin and keeps the granted request stable until the handshake completes.
// - Records the issuer of every read and routes in-order read data back to that issuer.

---
 rtl/bst_mem_pkg.sv | 22 ++
 rtl/rd_tag_fifo.sv | 50 +++++
 rtl/mem_request_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_request_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bst_mem_pkg.sv
// Shared types for the BST memory path.
// REQ_INS / REQ_SRCH identify the two requesters on the shared memory port.
// req_t bundles one request at the default widths.
// arb_state_t is the arbiter grant-lock state.
package bst_mem_pkg;

   localparam int BST_ADDR_W  = 16;
   localparam int BST_DATA_W  = 32;
   localparam int BST_MAX_OUT = 8;

   typedef enum logic {REQ_INS = 1'b0, REQ_SRCH = 1'b1} req_id_t;

   typedef struct packed {
      logic                  rd;
      logic                  wr;
      logic [BST_ADDR_W-1:0] addr;
      logic [BST_DATA_W-1:0] wr_data;
   } req_t;

   typedef enum logic {ARB_OPEN = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;

endpackage

// File: rtl/rd_tag_fifo.sv
// Tag FIFO that records which requester issued each outstanding read.
// The width is 1 bit and dout is first-word fall-through.
// Ports:
//   aclk, aresetn  clock and async active-low reset
//   push, din      write one tag
//   pop            drop the head tag; dout is the current head
//   full, empty    occupancy flags
// Push while full is legal only together with pop. The arbiter guarantees this.
module rd_tag_fifo #(
   parameter int DEPTH = 8
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit tells full apart from empty when the indices match.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [DEPTH-1:0] r_mem;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mem    <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin merge of the insert/delete engine (ins_*) and the search engine
// (srch_*) onto the single mem_* request port.
// Read data comes back in order and is returned to whichever engine issued the read.
// Ports:
//   aclk, aresetn                      clock, async active-low reset
//   ins_* / srch_*                     per-engine request and read-return signals
//   mem_valid/ready/rd/wr/addr/wr_data request port toward memory_driver
//   mem_rd_valid/mem_rd_data           in-order read response
//   err_unexp_rd, err_illegal          sticky protocol error flags
//
// state      | meaning
// ARB_OPEN   | no grant held; winner picked combinationally each cycle
// ARB_LOCKED | grant_q presented last cycle without mem_ready; keep driving it
module mem_request_arbiter
   import bst_mem_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH  = BST_ADDR_W,
   parameter int RAM_DATA_WIDTH  = BST_DATA_W,
   parameter int MAX_OUTSTANDING = BST_MAX_OUT
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      ins_valid,
   output logic                      ins_ready,
   input  logic                      ins_rd,
   input  logic                      ins_wr,
   input  logic [RAM_ADDR_WIDTH-1:0] ins_addr,
   input  logic [RAM_DATA_WIDTH-1:0] ins_wr_data,
   output logic                      ins_rd_valid,
   output logic [RAM_DATA_WIDTH-1:0] ins_rd_data,
   input  logic                      srch_valid,
   output logic                      srch_ready,
   input  logic                      srch_rd,
   input  logic                      srch_wr,
   input  logic [RAM_ADDR_WIDTH-1:0] srch_addr,
   input  logic [RAM_DATA_WIDTH-1:0] srch_wr_data,
   output logic                      srch_rd_valid,
   output logic [RAM_DATA_WIDTH-1:0] srch_rd_data,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic                      mem_rd,
   output logic                      mem_wr,
   output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
   output logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
   input  logic                      mem_rd_valid,
   input  logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
   output logic                      err_unexp_rd,
   output logic                      err_illegal
);

   arb_state_t r_state, w_state_nxt;
   req_id_t    r_grant, w_grant_nxt;
   req_id_t    r_rr_ptr, w_rr_nxt;
   req_id_t    w_winner;
   logic       w_win_valid;
   logic       w_hs;
   logic       w_full, w_empty, w_tag;
   logic       w_rd_blocked, w_cand_ins, w_cand_srch;
   logic       w_sel_ins, w_pop, w_push;

   // A response in this cycle frees a slot, so a full FIFO still takes a read.
   assign w_rd_blocked = w_full & ~mem_rd_valid;
   assign w_cand_ins   = ins_valid  & ~(ins_rd  & w_rd_blocked);
   assign w_cand_srch  = srch_valid & ~(srch_rd & w_rd_blocked);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= ARB_OPEN;
         r_grant  <= REQ_INS;
         r_rr_ptr <= REQ_INS;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = ARB_OPEN;
      w_grant_nxt = r_grant;
      w_rr_nxt    = r_rr_ptr;
      w_winner    = r_grant;
      w_win_valid = 1'b0;
      case (r_state)
         ARB_OPEN: begin
            if (w_cand_ins && w_cand_srch) w_winner = r_rr_ptr;
            else if (w_cand_srch)          w_winner = REQ_SRCH;
            else                           w_winner = REQ_INS;
            w_win_valid = w_cand_ins | w_cand_srch;
         end
         ARB_LOCKED: begin
            w_winner    = r_grant;
            w_win_valid = (r_grant == REQ_INS) ? ins_valid : srch_valid;
         end
         default: ;
      endcase
      // Outputs are held low while reset is asserted, not just after the next edge.
      mem_valid = w_win_valid & aresetn;
      w_hs      = mem_valid & mem_ready;
      if (mem_valid && !mem_ready) begin
         w_state_nxt = ARB_LOCKED;
         w_grant_nxt = w_winner;
      end else if (w_hs) begin
         w_rr_nxt = (w_winner == REQ_INS) ? REQ_SRCH : REQ_INS;
      end
   end

   assign w_sel_ins   = (w_winner == REQ_INS);
   assign mem_rd      = mem_valid & (w_sel_ins ? ins_rd : srch_rd);
   assign mem_wr      = mem_valid & (w_sel_ins ? ins_wr : srch_wr);
   assign mem_addr    = mem_valid ? (w_sel_ins ? ins_addr : srch_addr) : '0;
   assign mem_wr_data = mem_valid ? (w_sel_ins ? ins_wr_data : srch_wr_data) : '0;
   assign ins_ready   = w_hs &  w_sel_ins;
   assign srch_ready  = w_hs & ~w_sel_ins;

   assign w_push = w_hs & mem_rd;
   assign w_pop  = mem_rd_valid & ~w_empty & aresetn;

   rd_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .aclk   (aclk),
      .aresetn(aresetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (w_winner == REQ_SRCH),
      .dout   (w_tag),
      .full   (w_full),
      .empty  (w_empty)
   );

   assign ins_rd_valid  = w_pop & ~w_tag;
   assign srch_rd_valid = w_pop &  w_tag;
   assign ins_rd_data   = ins_rd_valid  ? mem_rd_data : '0;
   assign srch_rd_data  = srch_rd_valid ? mem_rd_data : '0;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_unexp_rd <= 1'b0;
         err_illegal  <= 1'b0;
      end else begin
         if (mem_rd_valid && w_empty) err_unexp_rd <= 1'b1;
         if (w_hs && (mem_rd == mem_wr)) err_illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        ins_valid, ins_ready, ins_rd, ins_wr, ins_rd_valid;
   logic [15:0] ins_addr;
   logic [31:0] ins_wr_data, ins_rd_data;
   logic        srch_valid, srch_ready, srch_rd, srch_wr, srch_rd_valid;
   logic [15:0] srch_addr;
   logic [31:0] srch_wr_data, srch_rd_data;
   logic        mem_valid, mem_ready, mem_rd, mem_wr, mem_rd_valid;
   logic [15:0] mem_addr;
   logic [31:0] mem_wr_data, mem_rd_data;
   logic        err_unexp_rd, err_illegal;

   int checks   = 0;
   int failures = 0;
   bit exp_q[$];

   always #5 aclk = ~aclk;

   mem_request_arbiter dut (
      .aclk(aclk), .aresetn(aresetn),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_rd(ins_rd), .ins_wr(ins_wr),
      .ins_addr(ins_addr), .ins_wr_data(ins_wr_data),
      .ins_rd_valid(ins_rd_valid), .ins_rd_data(ins_rd_data),
      .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_rd(srch_rd), .srch_wr(srch_wr),
      .srch_addr(srch_addr), .srch_wr_data(srch_wr_data),
      .srch_rd_valid(srch_rd_valid), .srch_rd_data(srch_rd_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .err_unexp_rd(err_unexp_rd), .err_illegal(err_illegal)
   );

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle();
      ins_valid = 0; ins_rd = 0; ins_wr = 0; ins_addr = '0; ins_wr_data = '0;
      srch_valid = 0; srch_rd = 0; srch_wr = 0; srch_addr = '0; srch_wr_data = '0;
      mem_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
   endtask

   task automatic do_reset();
      idle();
      aresetn = 0;
      step(); step();
      aresetn = 1;
      step();
      exp_q.delete();
   endtask

   // Presents a single request with mem_ready high and records expected read tags.
   task automatic issue(input bit id, input bit rd, input bit wr, input logic [15:0] addr);
      if (id == 0) begin
         ins_valid = 1; ins_rd = rd; ins_wr = wr; ins_addr = addr;
      end else begin
         srch_valid = 1; srch_rd = rd; srch_wr = wr; srch_addr = addr;
      end
      mem_ready = 1;
      @(negedge aclk);
      checks++;
      if ((id ? srch_ready : ins_ready) !== 1'b1 || mem_addr !== addr) begin
         failures++;
         $display("FAIL issue id=%0d ready=%b/%b addr=%h exp_addr=%h", id, ins_ready, srch_ready, mem_addr, addr);
      end
      if (rd) exp_q.push_back(id);
      step();
      idle();
   endtask

   // Drives one read response and checks it against the scoreboard head.
   task automatic respond(input logic [31:0] data);
      bit e;
      mem_rd_valid = 1; mem_rd_data = data;
      @(negedge aclk);
      checks++;
      if (exp_q.size() == 0) begin
         if (ins_rd_valid !== 1'b0 || srch_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL respond_none ins_rd_valid=%b srch_rd_valid=%b exp 0/0", ins_rd_valid, srch_rd_valid);
         end
      end else begin
         e = exp_q.pop_front();
         if (ins_rd_valid !== !e || srch_rd_valid !== e ||
             (e ? srch_rd_data : ins_rd_data) !== data) begin
            failures++;
            $display("FAIL respond tag=%0d ins_v=%b srch_v=%b ins_d=%h srch_d=%h exp_d=%h",
                     e, ins_rd_valid, srch_rd_valid, ins_rd_data, srch_rd_data, data);
         end
      end
      step();
      mem_rd_valid = 0; mem_rd_data = '0;
   endtask

   task automatic test_reset();
      idle();
      aresetn = 0;
      ins_valid = 1; ins_wr = 1; ins_addr = 16'h1234; mem_ready = 1; mem_rd_valid = 1;
      #2;
      checks++;
      if (mem_valid !== 0 || ins_ready !== 0 || mem_addr !== 0 || ins_rd_valid !== 0 ||
          err_unexp_rd !== 0 || err_illegal !== 0) begin
         failures++;
         $display("FAIL reset mem_valid=%b ins_ready=%b mem_addr=%h rd_valid=%b errs=%b%b exp all 0",
                  mem_valid, ins_ready, mem_addr, ins_rd_valid, err_unexp_rd, err_illegal);
      end
      do_reset();
   endtask

   task automatic test_round_robin();
      do_reset();
      ins_valid = 1; ins_wr = 1; ins_addr = 16'h0100; ins_wr_data = 32'h11;
      srch_valid = 1; srch_wr = 1; srch_addr = 16'h0200; srch_wr_data = 32'h22;
      mem_ready = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         checks++;
         if ((c % 2 == 0) ? (ins_ready !== 1 || srch_ready !== 0 || mem_addr !== 16'h0100 || mem_wr_data !== 32'h11)
                          : (ins_ready !== 0 || srch_ready !== 1 || mem_addr !== 16'h0200 || mem_wr_data !== 32'h22)) begin
            failures++;
            $display("FAIL rr cycle=%0d ins_ready=%b srch_ready=%b mem_addr=%h", c, ins_ready, srch_ready, mem_addr);
         end
         step();
      end
      idle();
   endtask

   task automatic test_lock();
      do_reset();
      ins_valid = 1; ins_rd = 1; ins_addr = 16'h0010;
      srch_valid = 1; srch_wr = 1; srch_addr = 16'h0020;
      mem_ready = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         checks++;
         if (mem_valid !== 1 || mem_addr !== 16'h0010 || mem_rd !== 1 || srch_ready !== 0 || ins_ready !== 0) begin
            failures++;
            $display("FAIL lock cycle=%0d mem_addr=%h mem_rd=%b srch_ready=%b exp addr 0010", c, mem_addr, mem_rd, srch_ready);
         end
         step();
      end
      mem_ready = 1;
      @(negedge aclk);
      checks++;
      if (ins_ready !== 1 || srch_ready !== 0 || mem_addr !== 16'h0010) begin
         failures++;
         $display("FAIL lock_release ins_ready=%b srch_ready=%b mem_addr=%h", ins_ready, srch_ready, mem_addr);
      end
      exp_q.push_back(0);
      step();
      ins_valid = 0; ins_rd = 0;
      @(negedge aclk);
      checks++;
      if (srch_ready !== 1 || mem_addr !== 16'h0020) begin
         failures++;
         $display("FAIL lock_next srch_ready=%b mem_addr=%h exp 1/0020", srch_ready, mem_addr);
      end
      step();
      idle();
      respond(32'h55);
   endtask

   task automatic test_interleaved_reads();
      do_reset();
      issue(0, 1, 0, 16'h0004);
      issue(1, 1, 0, 16'h0008);
      issue(0, 1, 0, 16'h000C);
      respond(32'hA);
      respond(32'hB);
      respond(32'hC);
   endtask

   task automatic test_full();
      bit e;
      do_reset();
      for (int i = 0; i < 8; i++) issue(i[0], 1, 0, 16'h0040 + 16'(i));
      ins_valid = 1; ins_rd = 1; ins_addr = 16'h0100;
      srch_valid = 1; srch_wr = 1; srch_addr = 16'h0200;
      mem_ready = 1;
      @(negedge aclk);
      checks++;
      if (ins_ready !== 0 || srch_ready !== 1 || mem_wr !== 1 || mem_addr !== 16'h0200) begin
         failures++;
         $display("FAIL full_write_pass ins_ready=%b srch_ready=%b mem_addr=%h exp 0/1/0200", ins_ready, srch_ready, mem_addr);
      end
      step();
      srch_valid = 0; srch_wr = 0;
      @(negedge aclk);
      checks++;
      if (ins_ready !== 0 || mem_valid !== 0) begin
         failures++;
         $display("FAIL full_block ins_ready=%b mem_valid=%b exp 0/0", ins_ready, mem_valid);
      end
      step();
      mem_rd_valid = 1; mem_rd_data = 32'h900;
      @(negedge aclk);
      e = exp_q.pop_front();
      checks++;
      if (ins_ready !== 1 || ins_rd_valid !== !e || srch_rd_valid !== e || ins_rd_data !== 32'h900) begin
         failures++;
         $display("FAIL full_push_pop ins_ready=%b ins_rd_valid=%b srch_rd_valid=%b data=%h exp 1/1/0/900",
                  ins_ready, ins_rd_valid, srch_rd_valid, ins_rd_data);
      end
      exp_q.push_back(0);
      step();
      idle();
      for (int i = 0; i < 8; i++) respond(32'h1000 + 32'(i));
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL full_drain left=%0d exp 0", exp_q.size());
      end
   endtask

   task automatic test_errors();
      do_reset();
      respond(32'hDEAD);
      checks++;
      if (err_unexp_rd !== 1 || err_illegal !== 0) begin
         failures++;
         $display("FAIL err_unexp err_unexp_rd=%b err_illegal=%b exp 1/0", err_unexp_rd, err_illegal);
      end
      step(); step();
      checks++;
      if (err_unexp_rd !== 1) begin
         failures++;
         $display("FAIL err_unexp_sticky err_unexp_rd=%b exp 1", err_unexp_rd);
      end
      issue(0, 1, 1, 16'h0077);
      checks++;
      if (err_illegal !== 1) begin
         failures++;
         $display("FAIL err_illegal err_illegal=%b exp 1", err_illegal);
      end
      respond(32'h77);
   endtask

   task automatic test_reset_midflight();
      do_reset();
      for (int i = 0; i < 3; i++) issue(0, 1, 0, 16'h0050 + 16'(i));
      srch_valid = 1; srch_rd = 1; srch_addr = 16'h0060; mem_ready = 0;
      step();
      aresetn = 0; mem_rd_valid = 1; mem_rd_data = 32'h1;
      #1;
      checks++;
      if (mem_valid !== 0 || srch_ready !== 0 || mem_addr !== 0 || mem_rd !== 0 ||
          ins_rd_valid !== 0 || srch_rd_valid !== 0 || ins_rd_data !== 0) begin
         failures++;
         $display("FAIL reset_mid mem_valid=%b srch_ready=%b mem_addr=%h ins_rd_valid=%b exp all 0",
                  mem_valid, srch_ready, mem_addr, ins_rd_valid);
      end
      exp_q.delete();
      idle();
      step();
      aresetn = 1;
      step();
      issue(1, 1, 0, 16'h0030);
      respond(32'h77);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_lock();
      test_interleaved_reads();
      test_full();
      test_errors();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
